// File: rtl/uart_tx.sv
// uart_tx: serial transmitter for the low byte of a Hack word, 8 data bits,
// no parity, one or two stop bits. A frame starts on a LOAD rising edge.
//
// state | meaning
// IDLE  | line high, waiting for a LOAD rising edge
// START | start bit, line low for one bit period
// DATA  | eight data bits, LSB first, one bit period each
// STOP  | line high for STOP_BITS bit periods, then back to IDLE
module uart_tx #(
    parameter int CLKS_PER_BIT = 868,
    parameter int STOP_BITS    = 1
) (
    input  logic        CLK_100MHz,
    input  logic        RESET,
    input  logic        LOAD,
    input  logic [15:0] IN,
    output logic        TX,
    output logic        TX_BUSY
);

    localparam int BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic STOP_LAST = 1'(STOP_BITS - 1);

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } state_t;

    state_t            state;
    logic              load_q;
    logic [BAUD_W-1:0] baud_cnt;
    logic [2:0]        bit_cnt;
    logic              stop_cnt;
    logic [7:0]        shift_reg;

    logic start_req;
    logic baud_done;

    assign start_req = LOAD && !load_q;
    assign baud_done = (baud_cnt == BAUD_LAST);

    // The high byte of the Hack word is deliberately never transmitted.
    logic unused_in_hi;
    assign unused_in_hi = ^IN[15:8];

    always_ff @(posedge CLK_100MHz) begin
        if (RESET) begin
            state     <= IDLE;
            load_q    <= 1'b0;
            baud_cnt  <= '0;
            bit_cnt   <= '0;
            stop_cnt  <= 1'b0;
            shift_reg <= '0;
            TX        <= 1'b1;
            TX_BUSY   <= 1'b0;
        end else begin
            load_q <= LOAD;
            case (state)
                IDLE: begin
                    if (start_req) begin
                        shift_reg <= IN[7:0];
                        baud_cnt  <= '0;
                        bit_cnt   <= '0;
                        stop_cnt  <= 1'b0;
                        TX        <= 1'b0;
                        TX_BUSY   <= 1'b1;
                        state     <= START;
                    end
                end
                START: begin
                    if (baud_done) begin
                        baud_cnt <= '0;
                        TX       <= shift_reg[0];
                        state    <= DATA;
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
                DATA: begin
                    if (baud_done) begin
                        baud_cnt <= '0;
                        if (bit_cnt == 3'd7) begin
                            TX    <= 1'b1;
                            state <= STOP;
                        end else begin
                            // Next bit is driven from shift_reg[1] on the same edge the register shifts.
                            bit_cnt   <= bit_cnt + 3'd1;
                            shift_reg <= {1'b0, shift_reg[7:1]};
                            TX        <= shift_reg[1];
                        end
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
                STOP: begin
                    if (baud_done) begin
                        baud_cnt <= '0;
                        if (stop_cnt == STOP_LAST) begin
                            TX_BUSY <= 1'b0;
                            state   <= IDLE;
                        end else begin
                            stop_cnt <= stop_cnt + 1'b1;
                        end
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
                default: begin
                    TX      <= 1'b1;
                    TX_BUSY <= 1'b0;
                    state   <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: directed checks of uart_tx framing, LOAD edge detection and reset,
// using one instance at 4 clocks/bit with 1 stop bit and one at 3 clocks/bit with 2.
module tb_uart_tx;

    logic CLK_100MHz = 1'b0;
    always #5 CLK_100MHz = ~CLK_100MHz;

    logic        reset;
    logic        load;
    logic [15:0] in_word;
    logic        tx;
    logic        tx_busy;

    logic        reset2;
    logic        load2;
    logic [15:0] in_word2;
    logic        tx2;
    logic        tx_busy2;

    int n_vectors     = 0;
    int n_miscompares = 0;

    uart_tx #(.CLKS_PER_BIT(4), .STOP_BITS(1)) dut (
        .CLK_100MHz (CLK_100MHz),
        .RESET      (reset),
        .LOAD       (load),
        .IN         (in_word),
        .TX         (tx),
        .TX_BUSY    (tx_busy)
    );

    uart_tx #(.CLKS_PER_BIT(3), .STOP_BITS(2)) dut2 (
        .CLK_100MHz (CLK_100MHz),
        .RESET      (reset2),
        .LOAD       (load2),
        .IN         (in_word2),
        .TX         (tx2),
        .TX_BUSY    (tx_busy2)
    );

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        n_vectors++;
        if (observed !== expected) begin
            n_miscompares++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, observed, expected, $time);
        end
    endtask

    task automatic tick();
        @(posedge CLK_100MHz);
        #1;
    endtask

    // Called one cycle after the start edge; slots[s] is the expected line level in bit slot s.
    task automatic run_frame(input string tag, input logic [9:0] slots, input int ncyc,
                             input int pulse_at, input logic [15:0] pulse_word);
        for (int k = 0; k < ncyc; k++) begin
            check({tag, "_tx"}, 32'(tx), 32'(slots[k / 4]));
            check({tag, "_busy"}, 32'(tx_busy), 32'd1);
            if (pulse_at >= 0) begin
                if (k == pulse_at) begin
                    load    = 1'b1;
                    in_word = pulse_word;
                end else if (k == pulse_at + 1) begin
                    load = 1'b0;
                end
            end
            tick();
        end
        if (ncyc == 40) begin
            check({tag, "_end_busy"}, 32'(tx_busy), 32'd0);
            check({tag, "_end_tx"}, 32'(tx), 32'd1);
        end
    endtask

    task automatic check_idle(input string tag, input int ncyc);
        for (int k = 0; k < ncyc; k++) begin
            check({tag, "_tx"}, 32'(tx), 32'd1);
            check({tag, "_busy"}, 32'(tx_busy), 32'd0);
            tick();
        end
    endtask

    initial begin
        reset    = 1'b1;
        load     = 1'b0;
        in_word  = 16'h0000;
        reset2   = 1'b1;
        load2    = 1'b0;
        in_word2 = 16'h0000;

        for (int k = 0; k < 3; k++) begin
            tick();
            check("rst_tx", 32'(tx), 32'd1);
            check("rst_busy", 32'(tx_busy), 32'd0);
            check("rst2_tx", 32'(tx2), 32'd1);
            check("rst2_busy", 32'(tx_busy2), 32'd0);
        end
        reset  = 1'b0;
        reset2 = 1'b0;

        for (int k = 0; k < 20; k++) begin
            tick();
            check("idle_tx", 32'(tx), 32'd1);
            check("idle_busy", 32'(tx_busy), 32'd0);
            check("idle2_tx", 32'(tx2), 32'd1);
            check("idle2_busy", 32'(tx_busy2), 32'd0);
        end

        // Single byte 0xAB: 0 | 1,1,0,1,0,1,0,1 | 1
        in_word = 16'h0AAB;
        load    = 1'b1;
        tick();
        load = 1'b0;
        run_frame("byte_ab", 10'b1_1010_1011_0, 40, -1, 16'h0000);
        check_idle("after_ab", 5);

        // Held LOAD: one 0xCD frame (1,0,1,1,0,0,1,1), nothing more for 200 cycles
        in_word = 16'h0ACD;
        load    = 1'b1;
        tick();
        run_frame("held", 10'b1_1100_1101_0, 40, -1, 16'h0000);
        check_idle("held_quiet", 159);
        load = 1'b0;
        tick();
        load = 1'b1;
        tick();
        load = 1'b0;
        run_frame("held_again", 10'b1_1100_1101_0, 40, -1, 16'h0000);
        check_idle("after_held", 5);

        // Second LOAD pulse (0xCD) at cycle 10 of an 0xAB frame is dropped
        in_word = 16'h00AB;
        load    = 1'b1;
        tick();
        load = 1'b0;
        run_frame("busy_drop", 10'b1_1010_1011_0, 40, 10, 16'h00CD);
        check_idle("busy_drop_quiet", 12);

        // Reset during data bit 3 of 0x55 (bit3 = 0), with LOAD raised under reset
        in_word = 16'h0055;
        load    = 1'b1;
        tick();
        load = 1'b0;
        run_frame("pre_rst", 10'b1_0101_0101_0, 18, -1, 16'h0000);
        check("pre_rst_bit3", 32'(tx), 32'd0);
        in_word = 16'h00C3;
        reset   = 1'b1;
        load    = 1'b1;
        tick();
        check("mid_rst_tx", 32'(tx), 32'd1);
        check("mid_rst_busy", 32'(tx_busy), 32'd0);
        reset = 1'b0;
        tick();
        load = 1'b0;
        run_frame("post_rst", 10'b1_1100_0011_0, 40, -1, 16'h0000);
        check_idle("after_post_rst", 5);

        // Two stop bits, 3 clocks/bit, byte 0x00: 27 low, 6 high, busy 33
        in_word2 = 16'hFF00;
        load2    = 1'b1;
        tick();
        load2 = 1'b0;
        for (int k = 0; k < 33; k++) begin
            check("sb2_tx", 32'(tx2), (k < 27) ? 32'd0 : 32'd1);
            check("sb2_busy", 32'(tx_busy2), 32'd1);
            tick();
        end
        check("sb2_end_busy", 32'(tx_busy2), 32'd0);
        check("sb2_end_tx", 32'(tx2), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
        $finish;
    end

endmodule
